ysyx_23060208_axil_sram: RTL and testbench

Parametrised AXI4-Lite slave memory model; the successor to the DPI-backed dsram/isram stubs. Holds a synthesisable internal word array instead of DPI calls. Provides full byte strobes, independent AW/W acceptance in any order, programmable read/write latency and SLVERR decode for out-of-range addresses. Sits behind the LSU/IFU AXI-Lite masters or an arbiter/crossbar port.

---
 rtl/ysyx_23060208_axil_pkg.sv | 21 ++
 rtl/ysyx_23060208_lat_cnt.sv | 31 +++
 rtl/ysyx_23060208_axil_sram.sv | 255 +++++++++++++++++++++++++
 tb/tb_ysyx_23060208_axil_sram.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_axil_pkg.sv
// rtl/ysyx_23060208_axil_pkg.sv - shared constants and FSM state types for the AXI-Lite SRAM
// Purpose: response codes and the read/write FSM state encodings.
// Ports: none (package).
package ysyx_23060208_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LAT  = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LAT  = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ysyx_23060208_lat_cnt.sv
// rtl/ysyx_23060208_lat_cnt.sv - 4-bit load/countdown latency counter
// Purpose: loaded with a cycle count, counts down to zero and holds there.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_load   load i_val this cycle (takes priority over counting)
//   i_val    value to load
//   o_done   count has reached zero
module ysyx_23060208_lat_cnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/ysyx_23060208_axil_sram.sv
// rtl/ysyx_23060208_axil_sram.sv - AXI4-Lite slave backed by an internal word array
// Purpose: byte-strobed single-outstanding AXI-Lite memory with programmable
//          read/write latency and SLVERR for addresses outside the window.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   sram_aw*/sram_w*/sram_b* write address, write data, write response channels
//   sram_ar*/sram_r*         read address, read data channels
module ysyx_23060208_axil_sram
  import ysyx_23060208_axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    RD_LAT     = 2,
  parameter int                    WR_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   sram_awaddr,
  input  logic                    sram_awvalid,
  output logic                    sram_awready,
  input  logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH/8-1:0] sram_wstrb,
  input  logic                    sram_wvalid,
  output logic                    sram_wready,
  output logic [1:0]              sram_bresp,
  output logic                    sram_bvalid,
  input  logic                    sram_bready,
  input  logic [ADDR_WIDTH-1:0]   sram_araddr,
  input  logic                    sram_arvalid,
  output logic                    sram_arready,
  output logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic [1:0]              sram_rresp,
  output logic                    sram_rvalid,
  input  logic                    sram_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------- write path ----------------
  wr_state_e             r_wstate, w_wstate_nxt;
  logic                  r_aw_got, r_w_got;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [1:0]            w_bresp_nxt;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_commit, w_wcnt_load, w_wcnt_done;
  logic [ADDR_WIDTH-1:0] w_woff;
  logic                  w_wr_ok;
  logic [IDX_W-1:0]      w_widx;

  assign w_aw_hs = sram_awvalid && r_awready;
  assign w_w_hs  = sram_wvalid && r_wready;
  assign w_b_hs  = r_bvalid && sram_bready;

  // Window check on the offset: anything above the array's byte span, or
  // below BASE_ADDR (offset wraps), is out of range.
  assign w_woff  = r_waddr - BASE_ADDR;
  assign w_wr_ok = (r_waddr >= BASE_ADDR) && ((w_woff >> (OFF_W + IDX_W)) == '0);
  assign w_widx  = w_woff[OFF_W+IDX_W-1:OFF_W];

  // The commit edge is the one that moves the FSM into W_RESP.
  assign w_commit    = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);
  assign w_wcnt_load = (r_wstate == W_IDLE) && (w_wstate_nxt == W_LAT);

  ysyx_23060208_lat_cnt u_wr_lat (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_wcnt_load),
    .i_val   (4'(WR_LAT - 1)),
    .o_done  (w_wcnt_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      if (w_b_hs) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_got <= 1'b1;
          r_waddr  <= sram_awaddr;
        end
        if (w_w_hs) begin
          r_w_got <= 1'b1;
          r_wdata <= sram_wdata;
          r_wstrb <= sram_wstrb;
        end
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if (r_aw_got && r_w_got) w_wstate_nxt = (WR_LAT == 0) ? W_RESP : W_LAT;
      W_LAT:  if (w_wcnt_done) w_wstate_nxt = W_RESP;
      W_RESP: if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        // Each channel's ready falls independently once that channel is held.
        w_awready_nxt = !(r_aw_got || w_aw_hs);
        w_wready_nxt  = !(r_w_got || w_w_hs);
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
          w_bvalid_nxt  = 1'b0;
          w_bresp_nxt   = RESP_OKAY;
        end
      end
      default: ;
    endcase
    if (w_commit) begin
      w_bvalid_nxt = 1'b1;
      w_bresp_nxt  = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (r_wstrb[i]) r_mem[w_widx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e             r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_arready, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_arready_nxt, w_rvalid_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic [1:0]            w_rresp_nxt;
  logic                  w_ar_hs, w_r_hs, w_rsample, w_rcnt_done;
  logic [ADDR_WIDTH-1:0] w_roff;
  logic                  w_rd_ok;
  logic [IDX_W-1:0]      w_ridx;

  assign w_ar_hs   = sram_arvalid && r_arready;
  assign w_r_hs    = r_rvalid && sram_rready;
  assign w_roff    = r_raddr - BASE_ADDR;
  assign w_rd_ok   = (r_raddr >= BASE_ADDR) && ((w_roff >> (OFF_W + IDX_W)) == '0);
  assign w_ridx    = w_roff[OFF_W+IDX_W-1:OFF_W];
  assign w_rsample = (r_rstate == R_LAT) && w_rcnt_done;

  // R_LAT is entered straight from the AR handshake, so it lasts RD_LAT+1
  // cycles and the sample edge lands RD_LAT+1 edges after the handshake.
  ysyx_23060208_lat_cnt u_rd_lat (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_ar_hs),
    .i_val   (4'(RD_LAT)),
    .o_done  (w_rcnt_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_raddr   <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      if (w_ar_hs) r_raddr <= sram_araddr;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_LAT;
      R_LAT:  if (w_rcnt_done) w_rstate_nxt = R_RESP;
      R_RESP: if (w_r_hs) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rstate)
      R_IDLE: w_arready_nxt = !w_ar_hs;
      R_LAT: begin
        // Array read sees the pre-commit contents on a same-edge write.
        if (w_rsample) begin
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = w_rd_ok ? r_mem[w_ridx] : '0;
          w_rresp_nxt  = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (w_r_hs) begin
          w_arready_nxt = 1'b1;
          w_rvalid_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign sram_awready = r_awready;
  assign sram_wready  = r_wready;
  assign sram_bvalid  = r_bvalid;
  assign sram_bresp   = r_bresp;
  assign sram_arready = r_arready;
  assign sram_rvalid  = r_rvalid;
  assign sram_rdata   = r_rdata;
  assign sram_rresp   = r_rresp;

endmodule

// File: tb/tb_ysyx_23060208_axil_sram.sv
// tb/tb_ysyx_23060208_axil_sram.sv - self-checking bench for the AXI-Lite SRAM
module tb_ysyx_23060208_axil_sram;

  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  ysyx_23060208_axil_sram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sram_awaddr  (awaddr),
    .sram_awvalid (awvalid),
    .sram_awready (awready),
    .sram_wdata   (wdata),
    .sram_wstrb   (wstrb),
    .sram_wvalid  (wvalid),
    .sram_wready  (wready),
    .sram_bresp   (bresp),
    .sram_bvalid  (bvalid),
    .sram_bready  (bready),
    .sram_araddr  (araddr),
    .sram_arvalid (arvalid),
    .sram_arready (arready),
    .sram_rdata   (rdata),
    .sram_rresp   (rresp),
    .sram_rvalid  (rvalid),
    .sram_rready  (rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  // lead > 0: W shown that many cycles before AW; lead < 0: AW leads.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc, n;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= ((lead > 0) ? lead : 0));
      wvalid  = !w_done && (cyc >= ((lead < 0) ? -lead : 0));
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      cyc++;
      if (aw_done != w_done) begin
        check("awready_indep", 32'(awready), 32'(!aw_done));
        check("wready_indep", 32'(wready), 32'(!w_done));
      end
    end
    awvalid = 0; wvalid = 0;
    check("aw_w_hs_done", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!bvalid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("b_latency", 32'(n), 32'(1 + WR_LAT));
    exp_resp = ref_in_range(addr) ? OKAY : SLVERR;
    check("bresp", 32'(bresp), 32'(exp_resp));
    if (ref_in_range(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[ref_idx(addr)][8*b +: 8] = data[8*b +: 8];
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("bvalid_after_b", 32'(bvalid), 32'd0);
    check("awready_after_b", 32'(awready), 32'd1);
    check("wready_after_b", 32'(wready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    bit hs;
    int n;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = ref_in_range(addr) ? ref_mem[ref_idx(addr)] : 32'd0;
    exp_resp = ref_in_range(addr) ? OKAY : SLVERR;
    araddr = addr; arvalid = 1; n = 0; hs = 0;
    while (!hs && n < 40) begin
      hs = arready;
      @(posedge clk); #1; n++;
    end
    arvalid = 0;
    check("ar_hs_done", 32'(hs), 32'd1);
    n = 0;
    while (!rvalid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("r_latency", 32'(n), 32'(1 + RD_LAT));
    check("rdata", rdata, exp_data);
    check("rresp", 32'(rresp), 32'(exp_resp));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp_data);
      check("rresp_hold", 32'(rresp), 32'(exp_resp));
      check("arready_hold", 32'(arready), 32'd0);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("rvalid_after_r", 32'(rvalid), 32'd0);
    check("arready_after_r", 32'(arready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          idx;
    rst = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1;
    #1;
    check("arready_before_edge", 32'(arready), 32'd0);
    @(posedge clk); #1;
    check("awready_first_edge", 32'(awready), 32'd1);
    check("wready_first_edge", 32'(wready), 32'd1);
    check("arready_first_edge", 32'(arready), 32'd1);

    // Full write then read, same-cycle AW/W.
    do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_read(BASE + 32'h10, 0);
    check("tp_full_word", ref_mem[4], 32'hDEADBEEF);
    // Partial strobe merge.
    do_write(BASE + 32'h10, 32'h11223344, 4'b0101, 0);
    do_read(BASE + 32'h10, 0);
    // W three cycles ahead of AW, then long rready stall.
    do_write(BASE + 32'h10, 32'hCAFEF00D, 4'hF, 3);
    do_read(BASE + 32'h10, 5);
    // Zero strobe, AW leading.
    do_write(BASE + 32'h10, 32'h0BADC0DE, 4'h0, -2);
    do_read(BASE + 32'h10, 0);
    // Out-of-range accesses above and below the window.
    do_write(BASE, 32'h01234567, 4'hF, 0);
    do_write(BASE + 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    do_read(BASE, 0);
    do_read(BASE + 32'h400, 1);
    do_read(BASE - 32'd4, 0);

    for (int i = 1; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0);

    // Reset in the middle of concurrent W_LAT and R_LAT.
    awaddr = BASE + 32'h14; wdata = ~ref_mem[5]; wstrb = 4'hF;
    araddr = BASE + 32'h14;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge clk); #1;
    #2 rst = 0;
    #1;
    check("async_rst_awready", 32'(awready), 32'd0);
    check("async_rst_wready", 32'(wready), 32'd0);
    check("async_rst_arready", 32'(arready), 32'd0);
    check("async_rst_bvalid", 32'(bvalid), 32'd0);
    check("async_rst_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk);
    #3 rst = 1;
    #1;
    check("rel_awready_pre_edge", 32'(awready), 32'd0);
    @(posedge clk); #1;
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready", 32'(wready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);
    do_read(BASE + 32'h14, 0);

    // Randomized traffic against the reference array.
    for (int it = 0; it < 40; it++) begin
      idx = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) addr = BASE + 32'h400 + 32'(4 * $urandom_range(0, 63));
        else                           addr = BASE - 32'd4 - 32'(4 * $urandom_range(0, 63));
      end else begin
        addr = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2);
      else
        do_read(addr, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
